// File: rtl/prog_loader_if.sv
// Word stream into the program loader: valid/ready handshake plus payload.
interface prog_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/prog_loader.sv
// Loads data then instruction words from a stream into two BRAMs, holds the core
// stalled meanwhile, then runs it and counts cycles. Optional LOADER_CHECKSUM_EN adds a trailing sum beat.
module prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CYC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] d_count,
    input  logic [ADDR_WIDTH-2:0] i_count,
    prog_loader_if.slave          s,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_bram_init_done,
    output logic                  pc_stall,
    output logic                  run,
    output logic                  error,
    output logic [CYC_WIDTH-1:0]  run_cycles
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        LOAD_I,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DRAIN,
        RUN,
        ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHECK;
`else
    localparam state_t AFTER_LOAD = DRAIN;
`endif

    localparam logic [ADDR_WIDTH-2:0] DEPTH   = {1'b1, {(ADDR_WIDTH-2){1'b0}}};
    localparam logic [ADDR_WIDTH-2:0] CNT_ONE = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [CYC_WIDTH-1:0]  CYC_ONE = {{(CYC_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-2:0] d_cnt_q, i_cnt_q, idx_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [DATA_WIDTH-1:0] w_dat_q;
    logic                  wr_d_q, wr_i_q;
    logic [CYC_WIDTH-1:0]  cyc_q;
    logic                  ready, accept, pay_acc, last_beat, load_go;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
`endif

    assign accept    = s.s_valid & ready;
    assign pay_acc   = accept & ((state_q == LOAD_D) | (state_q == LOAD_I));
    assign last_beat = (state_q == LOAD_D) ? (idx_q == d_cnt_q - CNT_ONE)
                                           : (idx_q == i_cnt_q - CNT_ONE);
    assign load_go   = start & ((state_q == IDLE) | (state_q == RUN) | (state_q == ERR));

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    if (d_count > DEPTH || i_count > DEPTH) state_d = ERR;
                    else if (d_count != '0)                 state_d = LOAD_D;
                    else if (i_count != '0)                 state_d = LOAD_I;
                    else                                    state_d = AFTER_LOAD;
                end
            end
            LOAD_D: begin
                ready = 1'b1;
                if (accept && last_beat) state_d = (i_cnt_q != '0) ? LOAD_I : AFTER_LOAD;
            end
            LOAD_I: begin
                ready = 1'b1;
                if (accept && last_beat) state_d = AFTER_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                ready = 1'b1;
                if (accept) state_d = (s.s_data == sum_q) ? DRAIN : ERR;
            end
`endif
            DRAIN:   state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            d_cnt_q  <= '0;
            i_cnt_q  <= '0;
            idx_q    <= '0;
            w_addr_q <= '0;
            w_dat_q  <= '0;
            wr_d_q   <= 1'b0;
            wr_i_q   <= 1'b0;
            cyc_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_d_q  <= pay_acc & (state_q == LOAD_D);
            wr_i_q  <= pay_acc & (state_q == LOAD_I);
            if (pay_acc) begin
                w_addr_q <= {idx_q[ADDR_WIDTH-3:0], 2'b00};
                w_dat_q  <= s.s_data;
            end
            if (load_go) begin
                d_cnt_q <= d_count;
                i_cnt_q <= i_count;
                idx_q   <= '0;
            end else if (pay_acc) begin
                idx_q <= last_beat ? '0 : idx_q + CNT_ONE;
            end
            // Any accepted start that begins a load resets the cycle count for the next run.
            if (load_go && state_d != ERR)            cyc_q <= '0;
            else if (state_q == RUN && cyc_q != '1)   cyc_q <= cyc_q + CYC_ONE;
`ifdef LOADER_CHECKSUM_EN
            if (load_go)      sum_q <= '0;
            else if (pay_acc) sum_q <= sum_q + s.s_data;
`endif
        end
    end

    assign s.s_ready        = ready;
    assign d_w_addr         = w_addr_q;
    assign d_w_dat          = w_dat_q;
    assign d_w_enb          = wr_d_q;
    assign i_w_addr         = w_addr_q;
    assign i_w_dat          = w_dat_q;
    assign i_w_enb          = wr_i_q;
    assign run              = (state_q == RUN);
    assign pc_stall         = ~run;
    assign d_bram_init_done = run;
    assign error            = (state_q == ERR);
    assign run_cycles       = cyc_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; builds with or without LOADER_CHECKSUM_EN.
module tb_prog_loader;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 32;

    typedef logic [DW-1:0] wq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-2:0] d_count, i_count;
    logic [AW-1:0] d_w_addr, i_w_addr;
    logic [DW-1:0] d_w_dat, i_w_dat;
    logic          d_w_enb, i_w_enb, d_bram_init_done, pc_stall, run, error;
    logic [CW-1:0] run_cycles;

    prog_loader_if #(.DATA_WIDTH(DW)) s_if();

    prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CYC_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .d_count(d_count), .i_count(i_count),
        .s(s_if),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .run(run),
        .error(error), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] d_log[$];
    logic [AW+DW-1:0] i_log[$];
    int both_hi = 0;
    logic [DW-1:0] prog[7];

    always @(negedge clk) begin
        if (d_w_enb) d_log.push_back({d_w_addr, d_w_dat});
        if (i_w_enb) i_log.push_back({i_w_addr, i_w_dat});
        if (d_w_enb && i_w_enb) both_hi++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        d_log.delete();
        i_log.delete();
        both_hi = 0;
    endtask

    task automatic do_start(input logic [AW-2:0] d, input logic [AW-2:0] i);
        start = 1'b1; d_count = d; i_count = i;
        tick();
        start = 1'b0;
    endtask

    function automatic wq_t seal(input wq_t w);
        wq_t r;
        logic [DW-1:0] acc;
        r = w;
        acc = '0;
        foreach (w[k]) acc = acc + w[k];
`ifdef LOADER_CHECKSUM_EN
        r.push_back(acc);
`endif
        if (acc === 'x) r.delete();
        return r;
    endfunction

    task automatic stream(input wq_t w, input bit bubbles, output bit ok);
        int n, cyc;
        bit ph, acc;
        n = 0; cyc = 0; ph = 1'b1; ok = 1'b1;
        while (n < w.size() && ok) begin
            s_if.s_valid = bubbles ? ph : 1'b1;
            ph = ~ph;
            s_if.s_data = w[n];
            acc = s_if.s_valid && s_if.s_ready;
            tick();
            if (acc) n++;
            cyc++;
            if (cyc > 2000) ok = 1'b0;
        end
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; d_count = '0; i_count = '0;
        s_if.s_valid = 1'b0; s_if.s_data = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({pc_stall, run, error, s_if.s_ready, d_w_enb, i_w_enb, d_bram_init_done} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=1000000",
                     {pc_stall, run, error, s_if.s_ready, d_w_enb, i_w_enb, d_bram_init_done});
        end
        total++;
        if (run_cycles !== '0) begin bad++; $display("FAIL reset_cycles got=%0d exp=0", run_cycles); end
        tick();
        total++;
        if (pc_stall !== 1'b1 || s_if.s_ready !== 1'b0) begin
            bad++; $display("FAIL reset_idle got stall=%b ready=%b exp 1/0", pc_stall, s_if.s_ready);
        end
    endtask

    task automatic check_prog_logs(input string tag);
        logic [AW+DW-1:0] e;
        total++;
        if (d_log.size() != 2 || i_log.size() != 5 || both_hi != 0) begin
            bad++;
            $display("FAIL %s_counts got d=%0d i=%0d both=%0d exp d=2 i=5 both=0",
                     tag, d_log.size(), i_log.size(), both_hi);
        end else begin
            for (int k = 0; k < 7; k++) begin
                e = {AW'(4 * (k < 2 ? k : k - 2)), prog[k]};
                total++;
                if ((k < 2 ? d_log[k] : i_log[k-2]) !== e) begin
                    bad++;
                    $display("FAIL %s_write%0d got=%h exp=%h", tag, k,
                             (k < 2 ? d_log[k] : i_log[k-2]), e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        wq_t w;
        bit ok;
        clear_logs();
        for (int k = 0; k < 7; k++) w.push_back(prog[k]);
        do_start(9'd2, 9'd5);
        stream(seal(w), 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_stream got=timeout exp=accepted"); end
        total++;
        if (run !== 1'b0) begin bad++; $display("FAIL b2b_drain got run=%b exp=0", run); end
        tick();
        total++;
        if ({run, pc_stall, d_bram_init_done} !== 3'b101) begin
            bad++; $display("FAIL b2b_run got=%b exp=101", {run, pc_stall, d_bram_init_done});
        end
        repeat (10) tick();
        total++;
        if (run_cycles !== 32'd10) begin bad++; $display("FAIL b2b_cycles got=%0d exp=10", run_cycles); end
        check_prog_logs("b2b");
    endtask

    task automatic test_bubbles();
        wq_t w;
        bit ok;
        clear_logs();
        for (int k = 0; k < 7; k++) w.push_back(prog[k]);
        do_start(9'd2, 9'd5);
        total++;
        if ({run, pc_stall, d_bram_init_done, error} !== 4'b0100 || run_cycles !== '0) begin
            bad++;
            $display("FAIL restart_from_run got flags=%b cycles=%0d exp 0100/0",
                     {run, pc_stall, d_bram_init_done, error}, run_cycles);
        end
        stream(seal(w), 1'b1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bub_stream got=timeout exp=accepted"); end
        tick();
        total++;
        if (run !== 1'b1) begin bad++; $display("FAIL bub_run got=%b exp=1", run); end
        check_prog_logs("bub");
    endtask

    task automatic test_d_zero();
        wq_t w;
        bit ok;
        clear_logs();
        w.push_back(32'hDEAD_BEEF);
        do_start(9'd0, 9'd1);
        stream(seal(w), 1'b0, ok);
        tick();
        total++;
        if (!ok || run !== 1'b1) begin bad++; $display("FAIL dz_run got ok=%b run=%b exp 1/1", ok, run); end
        total++;
        if (d_log.size() != 0 || i_log.size() != 1) begin
            bad++; $display("FAIL dz_counts got d=%0d i=%0d exp d=0 i=1", d_log.size(), i_log.size());
        end else begin
            total++;
            if (i_log[0] !== {10'h000, 32'hDEAD_BEEF}) begin
                bad++; $display("FAIL dz_write got=%h exp=%h", i_log[0], {10'h000, 32'hDEAD_BEEF});
            end
        end
    endtask

    task automatic test_overflow();
        wq_t w;
        bit ok;
        clear_logs();
        do_start(9'd3, 9'd257);
        total++;
        if ({error, pc_stall, s_if.s_ready, run} !== 4'b1100) begin
            bad++; $display("FAIL ovf_err got=%b exp=1100", {error, pc_stall, s_if.s_ready, run});
        end
        s_if.s_valid = 1'b1; s_if.s_data = 32'h1234_5678;
        repeat (3) tick();
        s_if.s_valid = 1'b0;
        total++;
        if (error !== 1'b1 || d_log.size() != 0 || i_log.size() != 0) begin
            bad++; $display("FAIL ovf_hold got err=%b writes=%0d exp 1/0", error, d_log.size() + i_log.size());
        end
        do_start(9'd1, 9'd1);
        total++;
        if (error !== 1'b0 || s_if.s_ready !== 1'b1) begin
            bad++; $display("FAIL ovf_clear got err=%b ready=%b exp 0/1", error, s_if.s_ready);
        end
        w.push_back(32'h11); w.push_back(32'h22);
        stream(seal(w), 1'b0, ok);
        tick();
        total++;
        if (!ok || run !== 1'b1) begin bad++; $display("FAIL ovf_recover got ok=%b run=%b exp 1/1", ok, run); end
    endtask

    task automatic test_capacity();
        wq_t w;
        bit ok;
        clear_logs();
        for (int k = 0; k < 256; k++) w.push_back(32'h1000_0000 + DW'(k));
        do_start(9'd0, 9'd256);
        total++;
        if (error !== 1'b0 || s_if.s_ready !== 1'b1) begin
            bad++; $display("FAIL cap_accept got err=%b ready=%b exp 0/1", error, s_if.s_ready);
        end
        stream(seal(w), 1'b0, ok);
        tick();
        total++;
        if (!ok || run !== 1'b1 || i_log.size() != 256) begin
            bad++; $display("FAIL cap_done got ok=%b run=%b writes=%0d exp 1/1/256", ok, run, i_log.size());
        end else begin
            total++;
            if (i_log[255] !== {10'h3FC, 32'h1000_00FF} || i_log[0] !== {10'h000, 32'h1000_0000}) begin
                bad++; $display("FAIL cap_addr got first=%h last=%h exp=%h/%h", i_log[0], i_log[255],
                                {10'h000, 32'h1000_0000}, {10'h3FC, 32'h1000_00FF});
            end
        end
    endtask

    task automatic test_rst_mid_load();
        wq_t w;
        bit ok;
        clear_logs();
        for (int k = 0; k < 3; k++) w.push_back(32'hA0 + DW'(k));
        do_start(9'd0, 9'd5);
        stream(w, 1'b0, ok);
        rst = 1'b1;
        tick();
        total++;
        if ({pc_stall, run, error, s_if.s_ready, d_w_enb, i_w_enb} !== 6'b100000) begin
            bad++; $display("FAIL rst_abort got=%b exp=100000",
                            {pc_stall, run, error, s_if.s_ready, d_w_enb, i_w_enb});
        end
        rst = 1'b0;
        tick();
        total++;
        if (!ok || i_log.size() != 3 || s_if.s_ready !== 1'b0) begin
            bad++; $display("FAIL rst_idle got ok=%b writes=%0d ready=%b exp 1/3/0", ok, i_log.size(), s_if.s_ready);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        wq_t w;
        bit ok;
        w.push_back(32'h5); w.push_back(32'h7); w.push_back(32'hC);
        do_start(9'd1, 9'd1);
        stream(w, 1'b0, ok);
        tick();
        total++;
        if (!ok || run !== 1'b1 || error !== 1'b0) begin
            bad++; $display("FAIL cks_good got ok=%b run=%b err=%b exp 1/1/0", ok, run, error);
        end
        w[2] = 32'hD;
        do_start(9'd1, 9'd1);
        stream(w, 1'b0, ok);
        total++;
        if (!ok || error !== 1'b1 || run !== 1'b0) begin
            bad++; $display("FAIL cks_bad got ok=%b err=%b run=%b exp 1/1/0", ok, error, run);
        end
        repeat (3) tick();
        total++;
        if (run !== 1'b0 || pc_stall !== 1'b1) begin
            bad++; $display("FAIL cks_hold got run=%b stall=%b exp 0/1", run, pc_stall);
        end
    endtask
`endif

    initial begin
        prog[0] = 32'h0000_0003; prog[1] = 32'h0000_0002;
        prog[2] = 32'h0000_0013; prog[3] = 32'h0010_0093; prog[4] = 32'h0020_0113;
        prog[5] = 32'h0030_8193; prog[6] = 32'h0000_006F;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_d_zero();
        test_overflow();
        test_capacity();
        test_rst_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequencer that loads a program image into the instruction BRAM and the data BRAM from a valid/ready word stream.
- Holds the core stalled while loading, then releases it and counts execution cycles.
- Replaces ad-hoc bench loading loops. Lets the same core be loaded from a bench, UART bridge or DMA source.
- Sits between the image source and the write ports of both bram32 instances, and drives the pc stall and init-done muxing.

Parameters:
- DATA_WIDTH, 32, stream word and BRAM word width
- ADDR_WIDTH, 10, BRAM byte-address width; capacity is 2^(ADDR_WIDTH-2) words per BRAM
- CYC_WIDTH, 32, width of the run-cycle counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- d_count  in  ADDR_WIDTH-1  data words to load; sampled on start
- i_count  in  ADDR_WIDTH-1  instruction words to load; sampled on start
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts the word
- s_data  in  DATA_WIDTH  stream word
- d_w_addr  out  ADDR_WIDTH  data BRAM byte address
- d_w_dat  out  DATA_WIDTH  data BRAM write data
- d_w_enb  out  1  data BRAM write enable
- i_w_addr  out  ADDR_WIDTH  instruction BRAM byte address
- i_w_dat  out  DATA_WIDTH  instruction BRAM write data
- i_w_enb  out  1  instruction BRAM write enable
- d_bram_init_done  out  1  hands data BRAM write-port control to the core
- pc_stall  out  1  stalls the pc
- run  out  1  core running; drives regfile read enable and instruction BRAM read enable
- error  out  1  load failure
- run_cycles  out  CYC_WIDTH  cycles spent in RUN

Behaviour:
Reset values:
- pc_stall=1; all other outputs 0; state IDLE; counters 0.
- rst mid-load aborts immediately; BRAM contents already written are left as is.

States: IDLE, LOAD_D, LOAD_I, CHECK (feature only), DRAIN, RUN, ERR.

IDLE:
- On start, latch d_count and i_count.
- If either count exceeds 2^(ADDR_WIDTH-2), go to ERR.
- Otherwise go to LOAD_D. If d_count=0, go to LOAD_I. If both are 0, go to DRAIN.

Stream handshake:
- s_ready=1 only in LOAD_D, LOAD_I and CHECK.
- A beat is accepted on a clk edge where s_valid&s_ready.
- s_valid low inserts bubbles with no writes.

Write timing (one cycle latency):
- A beat accepted at edge N drives addr/dat/w_enb high during cycle N+1, for exactly one cycle.
- The word at index k is written to byte address k*4; index restarts at 0 per region.
- d_w_enb and i_w_enb are never both high.

Transitions:
- The last data beat moves to LOAD_I, or to CHECK/DRAIN if i_count=0.
- The last instruction beat moves to CHECK (feature) or DRAIN.
- DRAIN lasts one cycle so the final write completes, then RUN.

RUN:
- pc_stall=0, run=1, d_bram_init_done=1.
- run_cycles increments every cycle and saturates at all-ones.
- On entry to LOAD_D, run_cycles clears.

Start handling:
- start in LOAD_*, CHECK or DRAIN is ignored.
- start in RUN or ERR restarts the load exactly as from IDLE: pc_stall=1, run=0, d_bram_init_done=0 and error=0 from the next cycle.

ERR:
- error=1, pc_stall=1, s_ready=0, no writes.
- Exit only via rst or start.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - A 32-bit running sum (mod 2^32) accumulates every accepted payload word.
  - After the last payload word, CHECK accepts one extra beat. If it equals the sum, go to DRAIN; otherwise go to ERR.
  - With both counts 0, the expected value is 0.
- Undefined: no CHECK state and no extra beat; the accumulator is not built.

Test Plan:
- Reset, then start with d_count=2, i_count=5 and 7 back-to-back beats (data 0x00000003, 0x00000002; then 5 sub-program words) -> d_w_enb at addr 0x0/0x4, i_w_enb at 0x0..0x10. run rises 2 cycles after the last accept. run_cycles=10 after 10 RUN cycles.
- Same load with s_valid toggling every other cycle -> identical addresses/data, one write per accepted beat, no duplicate writes.
- start with d_count=0, i_count=1 -> no d_w_enb. Single i_w_enb at 0x0. RUN reached.
- start with i_count=257, ADDR_WIDTH=10 -> ERR next cycle, error=1, pc_stall=1, s_ready=0. A following valid start clears error.
- rst asserted after 3 of 5 instruction beats -> next cycle pc_stall=1, all enables 0, state IDLE.
- LOADER_CHECKSUM_EN with d_count=1 (0x5), i_count=1 (0x7): checksum 0xC -> RUN; checksum 0xD -> ERR, run stays 0.
